seg7_capture: RTL and testbench

//  Receive end of the multiplexed 7-segment display interface: samples active-low segment

---
 rtl/seg7_pkg.sv | 23 ++
 rtl/seg7_capture_if.sv | 22 ++
 rtl/seg7_to_bcd.sv | 36 +++
 rtl/seg7_capture.sv | 138 +++++++++++++
 tb/tb_seg7_capture.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment readback path: active-low segment
// patterns, special digit codes and the slot-capture FSM states.
package seg7_pkg;

    // Patterns are g..a (seg[6]..seg[0]), active-low.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] DIG_BLANK = 4'hF;
    localparam logic [3:0] DIG_ERR   = 4'hE;

    typedef enum logic [1:0] {WAIT, SETTLE, HOLD} state_t;

endpackage

// File: rtl/seg7_capture_if.sv
// Display bus as seen by the readback block: the multiplexed segment/anode
// lines plus the assembled-frame outputs.
interface seg7_capture_if #(
    parameter int NUM_DIGITS = 4
);
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   an;
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    err;
    logic                    frame_valid;

    modport master (
        output seg, an,
        input  digits, blank, err, frame_valid
    );

    modport slave (
        input  seg, an,
        output digits, blank, err, frame_valid
    );
endinterface

// File: rtl/seg7_to_bcd.sv
// Inverse 7-segment decoder: active-low pattern -> BCD code, with flags for
// an all-off (blank) slot and for patterns that match no digit.
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code,
    output logic       blank,
    output logic       error
);

    always_comb begin
        // NOTE: every output gets a default before the case, so no path can infer a latch.
        code  = DIG_ERR;
        blank = 1'b0;
        error = 1'b0;
        case (seg)
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_BLANK: begin
                code  = DIG_BLANK;
                blank = 1'b1;
            end
            default:   error = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// Samples a multiplexed 7-segment bus, captures each digit slot once it has
// been stable long enough, and publishes whole frames with a 1-cycle strobe.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input logic            clk,
    input logic            rst,
    seg7_capture_if.slave  bus
);

    localparam int SW     = 7 + NUM_DIGITS;
    localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic [SW-1:0]                samp, samp_d;
    logic [6:0]                   samp_seg;
    logic [NUM_DIGITS-1:0]        samp_an;
    state_t                       state, state_next;
    logic [CNT_W-1:0]             cnt, cnt_next;
    logic                         capture, an_ok, changed, commit;
    logic [SLOT_W-1:0]            slot;
    logic [NUM_DIGITS-1:0]        slot_mask;
    logic [3:0]                   dec_code;
    logic                         dec_blank, dec_error;
    logic [NUM_DIGITS-1:0]        seen;
    logic [NUM_DIGITS-1:0][3:0]   shadow_code;
    logic [NUM_DIGITS-1:0]        shadow_blank;
    logic                         frame_err;

    assign {samp_seg, samp_an} = samp;
    assign an_ok     = $onehot(~samp_an);
    assign changed   = (samp != samp_d);
    assign commit    = &seen;
    assign slot_mask = capture ? ~samp_an : '0;

    seg7_to_bcd u_dec (
        .seg   (samp_seg),
        .code  (dec_code),
        .blank (dec_blank),
        .error (dec_error)
    );

    always_comb begin
        slot = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (!samp_an[i]) slot = SLOT_W'(i);
    end

    // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            samp   <= '1;
            samp_d <= '1;
            state  <= WAIT;
            cnt    <= '0;
        end else begin
            samp   <= {bus.seg, bus.an};
            samp_d <= samp;
            state  <= state_next;
            cnt    <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        case (state)
            WAIT: begin
                if (an_ok) begin
                    state_next = SETTLE;
                    cnt_next   = CNT_W'(1);
                end else begin
                    cnt_next   = '0;
                end
            end
            SETTLE: begin
                if (changed) begin
                    if (an_ok) begin
                        cnt_next   = CNT_W'(1);
                    end else begin
                        state_next = WAIT;
                        cnt_next   = '0;
                    end
                end else begin
                    cnt_next = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
                    if (cnt_next == CNT_MAX) begin
                        capture    = 1'b1;
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (changed) begin
                    state_next = an_ok ? SETTLE : WAIT;
                    cnt_next   = an_ok ? CNT_W'(1) : '0;
                end
            end
            default: begin
                state_next = WAIT;
                cnt_next   = '0;
            end
        endcase
    end

    // A capture landing on the commit edge starts the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: shadow registers are reset too, so a partial frame after reset never publishes X.
            seen            <= '0;
            shadow_code     <= {NUM_DIGITS{DIG_BLANK}};
            shadow_blank    <= '1;
            frame_err       <= 1'b0;
            bus.digits      <= '1;
            bus.blank       <= '1;
            bus.err         <= 1'b0;
            bus.frame_valid <= 1'b0;
        end else begin
            bus.frame_valid <= commit;
            if (commit) begin
                bus.digits <= shadow_code;
                bus.blank  <= shadow_blank;
                bus.err    <= frame_err;
            end
            seen      <= (commit ? '0 : seen) | slot_mask;
            frame_err <= (frame_err & ~commit) | (capture & dec_error);
            if (capture) begin
                shadow_code[slot]  <= dec_code;
                shadow_blank[slot] <= dec_blank;
            end
        end
    end

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: table of full-frame scans plus hand-written
// reset, glitch, illegal-anode and rescan sequences.
module tb_seg7_capture;
    import seg7_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   fv_total = 0;
    int   fv_mark;

    always #5 clk = ~clk;

    seg7_capture_if #(.NUM_DIGITS(4)) bus ();

    seg7_capture #(
        .NUM_DIGITS    (4),
        .STABLE_CYCLES (4),
        .CNT_W         (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(negedge clk) if (bus.frame_valid === 1'b1) fv_total++;

    typedef struct packed {
        logic [3:0][6:0] segs;
        logic [15:0]     digits;
        logic [3:0]      blank;
        logic            err;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
        bus.an  = an;
        bus.seg = seg;
        repeat (n) @(negedge clk);
    endtask

    task automatic slot(input int i, input logic [6:0] seg, input int n);
        logic [3:0] sel;
        sel = 4'b0001 << i;
        drive(~sel, seg, n);
    endtask

    task automatic check_frame(input string name, input int pulses, input logic [15:0] d,
                               input logic [3:0] b, input logic e);
        check({name, " pulses"}, 32'(fv_total - fv_mark), 32'(pulses));
        check({name, " digits"}, 32'(bus.digits), 32'(d));
        check({name, " blank"},  32'(bus.blank), 32'(b));
        check({name, " err"},    32'(bus.err), 32'(e));
    endtask

    initial begin
        vecs[0] = '{segs: {SEG_1, SEG_2, SEG_3, SEG_4}, digits: 16'h1234, blank: 4'b0000, err: 1'b0};
        vecs[1] = '{segs: {SEG_5, SEG_7, SEG_0, SEG_9}, digits: 16'h5709, blank: 4'b0000, err: 1'b0};
        vecs[2] = '{segs: {7'b0101010, SEG_BLANK, SEG_8, SEG_6}, digits: 16'hEF86, blank: 4'b0100, err: 1'b1};
        vecs[3] = '{segs: {SEG_0, SEG_9, SEG_8, SEG_7}, digits: 16'h0987, blank: 4'b0000, err: 1'b0};
        vecs[4] = '{segs: {SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK}, digits: 16'hFFFF, blank: 4'b1111, err: 1'b0};

        rst = 1'b1;
        bus.an  = 4'hF;
        bus.seg = SEG_BLANK;
        repeat (3) @(negedge clk);
        check("reset digits", 32'(bus.digits), 32'hFFFF);
        check("reset blank",  32'(bus.blank), 32'hF);
        check("reset err",    32'(bus.err), 32'h0);
        check("reset fv",     32'(bus.frame_valid), 32'h0);
        rst = 1'b0;
        drive(4'hF, SEG_BLANK, 4);

        for (int v = 0; v < 5; v++) begin
            fv_mark = fv_total;
            for (int i = 0; i < 4; i++) slot(i, vecs[v].segs[i], 8);
            drive(4'hF, SEG_BLANK, 4);
            check_frame($sformatf("vec%0d", v), 1, vecs[v].digits, vecs[v].blank, vecs[v].err);
        end

        // Reset mid-frame: slots 0/1 seen before reset must not count afterwards.
        fv_mark = fv_total;
        slot(0, SEG_1, 8);
        slot(1, SEG_2, 4);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst digits", 32'(bus.digits), 32'hFFFF);
        check("midrst blank",  32'(bus.blank), 32'hF);
        check("midrst err",    32'(bus.err), 32'h0);
        check("midrst fv",     32'(bus.frame_valid), 32'h0);
        rst = 1'b0;
        slot(2, SEG_3, 8);
        slot(3, SEG_4, 8);
        drive(4'hF, SEG_BLANK, 4);
        check("midrst partial", 32'(fv_total - fv_mark), 32'h0);
        slot(0, SEG_5, 8);
        slot(1, SEG_6, 8);
        drive(4'hF, SEG_BLANK, 4);
        check_frame("midrst complete", 1, 16'h4365, 4'b0000, 1'b0);

        // Glitch: 3-cycle "2" on slot 0 must be ignored in favour of the stable "8".
        fv_mark = fv_total;
        slot(0, SEG_2, 3);
        slot(0, SEG_8, 8);
        slot(1, SEG_1, 8);
        slot(2, SEG_2, 8);
        slot(3, SEG_3, 8);
        drive(4'hF, SEG_BLANK, 4);
        check_frame("glitch", 1, 16'h3218, 4'b0000, 1'b0);

        // Illegal anode patterns: nothing captured, FSM stays in WAIT.
        fv_mark = fv_total;
        drive(4'b1100, SEG_1, 10);
        check("illegal 1100 state", 32'(dut.state), 32'(WAIT));
        drive(4'b0011, SEG_1, 10);
        check("illegal 0011 state", 32'(dut.state), 32'(WAIT));
        drive(4'b1111, SEG_1, 10);
        check("illegal 1111 state", 32'(dut.state), 32'(WAIT));
        slot(0, SEG_9, 8);
        slot(1, SEG_8, 8);
        slot(2, SEG_7, 8);
        drive(4'hF, SEG_BLANK, 4);
        check("illegal no frame", 32'(fv_total - fv_mark), 32'h0);
        slot(3, SEG_6, 8);
        drive(4'hF, SEG_BLANK, 4);
        check_frame("illegal then slot3", 1, 16'h6789, 4'b0000, 1'b0);

        // Rescan: slot 1 shows 5 then 7 before slot 3 completes the frame.
        fv_mark = fv_total;
        slot(0, SEG_0, 8);
        slot(1, SEG_5, 8);
        slot(2, SEG_9, 8);
        slot(1, SEG_7, 8);
        slot(3, SEG_4, 8);
        drive(4'hF, SEG_BLANK, 4);
        check_frame("rescan", 1, 16'h4970, 4'b0000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
